// File: rtl/led_pkg.sv
// Shared widths, codes and mode sequencing helpers for the LED mode controller
// and the mode engines it drives.
package led_pkg;

   localparam int LED_W      = 18;
   localparam int STATE_W    = 3;
   localparam int MODE_W     = 2;
   localparam int MODE_COUNT = 3;

   localparam logic [STATE_W-1:0] FIRST_STATE = 3'b000;

   typedef enum logic [MODE_W-1:0] {
      MODE_0 = 2'd0,
      MODE_1 = 2'd1,
      MODE_2 = 2'd2
   } mode_t;

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_0:  return MODE_1;
         MODE_1:  return MODE_2;
         default: return MODE_0;
      endcase
   endfunction

   function automatic logic [MODE_COUNT-1:0] mode_onehot(input mode_t m);
      case (m)
         MODE_0:  return 3'b001;
         MODE_1:  return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability filter for the mode button; emits a
// one-cycle press pulse on each accepted 0-to-1 level change.
module btn_debounce #(
   parameter int DEBOUNCE = 500000
) (
   input  logic clk,
   input  logic RESET,
   input  logic BTN,
   output logic press
);

   localparam int DW = $clog2(DEBOUNCE) + 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);

   logic          sync_a;
   logic          sync_b;
   logic          level;
   logic [DW-1:0] deb_cnt;
   logic          primed;
   logic          armed;

   // A press only counts once the button has been seen released after reset,
   // so a button held through reset does not switch modes on its own.
   always_ff @(posedge clk) begin
      if (RESET) begin
         sync_a  <= 1'b0;
         sync_b  <= 1'b0;
         level   <= 1'b0;
         deb_cnt <= '0;
         primed  <= 1'b0;
         armed   <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_a <= BTN;
         sync_b <= sync_a;
         primed <= 1'b1;
         press  <= 1'b0;
         if (primed && !sync_a && !sync_b)
            armed <= 1'b1;
         if (sync_b == level) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            deb_cnt <= '0;
            level   <= sync_b;
            press   <= sync_b & armed;
         end else begin
            deb_cnt <= deb_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/mode_controller.sv
// Mode selector: divided PULSE clock, debounced mode button, one-hot engine
// enables and LED mux. Optional macro MODE_CLEAN_SWITCH_EN defers switches.
//
// state  | meaning
// MODE_0 | engine 1 enabled, LEDR shows LEDr1
// MODE_1 | engine 2 enabled, LEDR shows LEDr2
// MODE_2 | engine 3 enabled, LEDR shows LEDr3
module mode_controller
   import led_pkg::*;
#(
   parameter int DIV      = 25000000,
   parameter int DEBOUNCE = 500000
) (
   input  logic               clk,
   input  logic               RESET,
   input  logic               BTN,
   input  logic [STATE_W-1:0] state1,
   input  logic [STATE_W-1:0] state2,
   input  logic [STATE_W-1:0] state3,
   input  logic [LED_W-1:0]   LEDr1,
   input  logic [LED_W-1:0]   LEDr2,
   input  logic [LED_W-1:0]   LEDr3,
   output logic               PULSE,
   output logic               MODE1_ON,
   output logic               MODE2_ON,
   output logic               MODE3_ON,
   output logic [LED_W-1:0]   LEDR,
   output logic [MODE_W-1:0]  MODE,
   output logic               PENDING
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2);

   logic [CW-1:0]         div_cnt;
   logic [CW-1:0]         div_nxt;
   mode_t                 mode_q;
   logic [MODE_COUNT-1:0] mode_on;
   logic [STATE_W-1:0]    active_state;
   logic                  press;
   logic                  switch_ok;
   logic                  apply;

   btn_debounce #(
      .DEBOUNCE (DEBOUNCE)
   ) u_btn_debounce (
      .clk   (clk),
      .RESET (RESET),
      .BTN   (BTN),
      .press (press)
   );

   always_comb begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + CW'(1);
   end

   always_comb begin
      LEDR         = LEDr1;
      active_state = state1;
      case (mode_q)
         MODE_1: begin
            LEDR         = LEDr2;
            active_state = state2;
         end
         MODE_2: begin
            LEDR         = LEDr3;
            active_state = state3;
         end
         default: begin
            LEDR         = LEDr1;
            active_state = state1;
         end
      endcase
   end

`ifdef MODE_CLEAN_SWITCH_EN
   // Switch only at the end of a PULSE period with the engine parked in its
   // first state, so the next engine starts from a clean boundary.
   assign switch_ok = (div_cnt == DIV_LAST) && (active_state == FIRST_STATE);
`else
   logic unused_state;
   assign unused_state = ^active_state;
   assign switch_ok    = 1'b1;
`endif

   assign apply = PENDING & switch_ok;

   // PULSE is computed from the next count so it tracks the counter value held.
   always_ff @(posedge clk) begin
      if (RESET) begin
         div_cnt <= '0;
         PULSE   <= 1'b0;
         mode_q  <= MODE_0;
         mode_on <= 3'b001;
         PENDING <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         PULSE   <= (div_nxt >= DIV_HALF);
         if (apply) begin
            mode_q  <= next_mode(mode_q);
            mode_on <= mode_onehot(next_mode(mode_q));
            PENDING <= 1'b0;
         end else if (press) begin
            PENDING <= 1'b1;
         end
      end
   end

   assign MODE     = mode_q;
   assign MODE1_ON = mode_on[0];
   assign MODE2_ON = mode_on[1];
   assign MODE3_ON = mode_on[2];

endmodule

// File: tb/tb_mode_controller.sv
// Directed bench for mode_controller with DIV=4, DEBOUNCE=3; covers both
// builds of MODE_CLEAN_SWITCH_EN.
module tb_mode_controller;
   import led_pkg::*;

   logic               clk = 1'b0;
   logic               RESET = 1'b1;
   logic               BTN = 1'b0;
   logic [STATE_W-1:0] state1 = 3'b000;
   logic [STATE_W-1:0] state2 = 3'b000;
   logic [STATE_W-1:0] state3 = 3'b000;
   logic [LED_W-1:0]   LEDr1 = 18'h15555;
   logic [LED_W-1:0]   LEDr2 = 18'h2AAAA;
   logic [LED_W-1:0]   LEDr3 = 18'h3F00F;
   logic               PULSE;
   logic               MODE1_ON;
   logic               MODE2_ON;
   logic               MODE3_ON;
   logic [LED_W-1:0]   LEDR;
   logic [MODE_W-1:0]  MODE;
   logic               PENDING;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [1:0] exp_div = 2'd0;

   mode_controller #(
      .DIV      (4),
      .DEBOUNCE (3)
   ) dut (
      .clk      (clk),
      .RESET    (RESET),
      .BTN      (BTN),
      .state1   (state1),
      .state2   (state2),
      .state3   (state3),
      .LEDr1    (LEDr1),
      .LEDr2    (LEDr2),
      .LEDr3    (LEDr3),
      .PULSE    (PULSE),
      .MODE1_ON (MODE1_ON),
      .MODE2_ON (MODE2_ON),
      .MODE3_ON (MODE3_ON),
      .LEDR     (LEDR),
      .MODE     (MODE),
      .PENDING  (PENDING)
   );

   always #5 clk = ~clk;

   // Reference divider: 0..3 wrapping, cleared by reset.
   always @(posedge clk) exp_div <= RESET ? 2'd0 : exp_div + 2'd1;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_mode(input string tag, input logic [1:0] m);
      logic [LED_W-1:0] led;
      logic [2:0]       oh;
      case (m)
         2'd0: begin led = LEDr1; oh = 3'b001; end
         2'd1: begin led = LEDr2; oh = 3'b010; end
         default: begin led = LEDr3; oh = 3'b100; end
      endcase
      check({tag, "_mode"}, 32'(MODE), 32'(m));
      check({tag, "_onehot"}, 32'({MODE3_ON, MODE2_ON, MODE1_ON}), 32'(oh));
      check({tag, "_ledr"}, 32'(LEDR), 32'(led));
   endtask

   task automatic do_press();
      BTN = 1'b1;
      tick(10);
      BTN = 1'b0;
      tick(6);
   endtask

   initial begin
      // Reset state
      tick(3);
      check("rst_pulse", 32'(PULSE), 32'd0);
      check("rst_pending", 32'(PENDING), 32'd0);
      check_mode("rst", 2'd0);
      RESET = 1'b0;

      // Free-running PULSE: 0,0,1,1 with counter 0,1,2,3
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check($sformatf("pulse_%0d", i), 32'(PULSE), 32'(exp_div >= 2'd2));
      end

      // Short bounce: no press
      BTN = 1'b1;
      tick(2);
      BTN = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         check($sformatf("bounce_pending_%0d", i), 32'(PENDING), 32'd0);
      end
      check_mode("bounce", 2'd0);

`ifndef MODE_CLEAN_SWITCH_EN
      // Press latency: pulse at edge 5, PENDING at 6, switch at 7
      BTN = 1'b1;
      tick(5);
      check("lat_pending_e5", 32'(PENDING), 32'd0);
      tick(1);
      check("lat_pending_e6", 32'(PENDING), 32'd1);
      check("lat_mode_e6", 32'(MODE), 32'd0);
      tick(1);
      check("lat_pending_e7", 32'(PENDING), 32'd0);
      check_mode("lat_e7", 2'd1);
      tick(3);
      BTN = 1'b0;
      tick(6);
      check_mode("hold_once", 2'd1);
      do_press();
      check_mode("seq2", 2'd2);
      do_press();
      check_mode("seq0", 2'd0);
`else
      // Engine 1 busy: switch held off, second press discarded
      state1 = 3'b010;
      do_press();
      check("clean_pending", 32'(PENDING), 32'd1);
      check("clean_mode", 32'(MODE), 32'd0);
      do_press();
      check("clean_pending2", 32'(PENDING), 32'd1);
      check("clean_mode2", 32'(MODE), 32'd0);
      state1 = 3'b000;
      for (int k = 0; k < 4 && exp_div != 2'd3; k++)
         tick(1);
      check("clean_pending_div3", 32'(PENDING), 32'd1);
      check("clean_mode_div3", 32'(MODE), 32'd0);
      tick(1);
      check("clean_pending_applied", 32'(PENDING), 32'd0);
      check_mode("clean_applied", 2'd1);
      tick(8);
      check_mode("clean_single", 2'd1);
      do_press();
      check_mode("clean_seq2", 2'd2);
      do_press();
      check_mode("clean_seq0", 2'd0);
`endif

      do_press();
      check_mode("pre_rst1", 2'd1);
      do_press();
      check_mode("pre_rst2", 2'd2);

      // Reset while a press is pending in MODE 2, button held through reset
      state3 = 3'b101;
      BTN = 1'b1;
      tick(6);
      check("prerst_pending", 32'(PENDING), 32'd1);
      check("prerst_mode", 32'(MODE), 32'd2);
      RESET = 1'b1;
      tick(1);
      check("rst2_pending", 32'(PENDING), 32'd0);
      check("rst2_pulse", 32'(PULSE), 32'd0);
      check_mode("rst2", 2'd0);
      tick(2);
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check($sformatf("rst2_pulse_%0d", i), 32'(PULSE), 32'(exp_div >= 2'd2));
         check($sformatf("held_pending_%0d", i), 32'(PENDING), 32'd0);
      end
      tick(4);
      check_mode("held", 2'd0);
      BTN = 1'b0;
      tick(6);
      state3 = 3'b000;
      check_mode("held_release", 2'd0);
      do_press();
      check_mode("post_rst_press", 2'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
